// File: rtl/parking_gate_arbiter_if.sv
// Gate-side handshake and occupancy status bundle for parking_gate_arbiter.
// master = gate sensors/keypads and display side, slave = the arbiter.
interface parking_gate_arbiter_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic [7:0] exit_code;
    logic       entry_ack;
    logic       entry_grant;
    logic [2:0] entry_slot;
    logic [7:0] entry_code;
    logic       exit_ack;
    logic       exit_grant;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic [7:0] occupancy;
    logic [3:0] available_slots;
    logic       full;

    modport master (
        output entry_req, exit_req, exit_slot, exit_code,
        input  entry_ack, entry_grant, entry_slot, entry_code,
        input  exit_ack, exit_grant, entry_gate_open, exit_gate_open,
        input  occupancy, available_slots, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot, exit_code,
        output entry_ack, entry_grant, entry_slot, entry_code,
        output exit_ack, exit_grant, entry_gate_open, exit_gate_open,
        output occupancy, available_slots, full
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter for one entry and one exit gate sharing an 8-slot
// occupancy table; resolves one request at a time, then runs its barrier window.
module parking_gate_arbiter #(
    parameter int unsigned GATE_OPEN_CYCLES = 4
) (
    input logic                  clock,
    input logic                  gl_reset,
    parking_gate_arbiter_if.slave gate
);
    localparam int unsigned TW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACK, GATE} state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;

    logic       favor_entry;
    logic       served_entry;
    logic       entry_ack_q;
    logic       entry_grant_q;
    logic [2:0] entry_slot_q;
    logic [7:0] entry_code_q;
    logic       exit_ack_q;
    logic       exit_grant_q;
    logic [7:0] occupancy_q;
    logic [3:0] available_q;
    logic       full_q;

    logic       take;
    logic       serve_entry;
    logic       exit_ok;
    logic       free_found;
    logic [2:0] free_idx;
    logic [7:0] occ_next;
    logic [3:0] occ_count;

    function automatic logic [7:0] slot_code(input logic [2:0] s);
        case (s)
            3'd0:    return 8'd1;
            3'd1:    return 8'd3;
            3'd2:    return 8'd6;
            3'd3:    return 8'd11;
            3'd4:    return 8'd19;
            3'd5:    return 8'd32;
            3'd6:    return 8'd53;
            default: return 8'd87;
        endcase
    endfunction

    assign take        = (state == IDLE) && (gate.entry_req || gate.exit_req);
    assign serve_entry = gate.entry_req && (!gate.exit_req || favor_entry);
    assign exit_ok     = occupancy_q[gate.exit_slot] &&
                         (gate.exit_code == slot_code(gate.exit_slot));

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!occupancy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    // Occupancy as it would look after serving the currently selected side.
    always_comb begin
        occ_next = occupancy_q;
        if (serve_entry) begin
            if (free_found) occ_next[free_idx] = 1'b1;
        end else if (exit_ok) begin
            occ_next[gate.exit_slot] = 1'b0;
        end
        occ_count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            occ_count = occ_count + 4'(occ_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (gl_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take) state_next = ACK;
            ACK:  state_next = (entry_grant_q || exit_grant_q) ? GATE : IDLE;
            GATE: if (timer == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gate.entry_gate_open = (state == GATE) && served_entry;
        gate.exit_gate_open  = (state == GATE) && !served_entry;
    end

    always_ff @(posedge clock) begin
        if (gl_reset) begin
            timer         <= '0;
            favor_entry   <= 1'b0;
            served_entry  <= 1'b0;
            entry_ack_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            entry_slot_q  <= '0;
            entry_code_q  <= '0;
            exit_ack_q    <= 1'b0;
            exit_grant_q  <= 1'b0;
            occupancy_q   <= '0;
            available_q   <= 4'd8;
            full_q        <= 1'b0;
        end else begin
            entry_ack_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            entry_slot_q  <= '0;
            entry_code_q  <= '0;
            exit_ack_q    <= 1'b0;
            exit_grant_q  <= 1'b0;

            if (state == ACK) begin
                timer <= TW'(GATE_OPEN_CYCLES - 1);
            end else if (state == GATE && timer != '0) begin
                timer <= timer - TW'(1);
            end

            if (take) begin
                served_entry <= serve_entry;
                favor_entry  <= !serve_entry;
                occupancy_q  <= occ_next;
                available_q  <= 4'd8 - occ_count;
                full_q       <= (occ_next == 8'hFF);
                if (serve_entry) begin
                    entry_ack_q <= 1'b1;
                    if (free_found) begin
                        entry_grant_q <= 1'b1;
                        entry_slot_q  <= free_idx;
                        entry_code_q  <= slot_code(free_idx);
                    end
                end else begin
                    exit_ack_q   <= 1'b1;
                    exit_grant_q <= exit_ok;
                end
            end
        end
    end

    assign gate.entry_ack       = entry_ack_q;
    assign gate.entry_grant     = entry_grant_q;
    assign gate.entry_slot      = entry_slot_q;
    assign gate.entry_code      = entry_code_q;
    assign gate.exit_ack        = exit_ack_q;
    assign gate.exit_grant      = exit_grant_q;
    assign gate.occupancy       = occupancy_q;
    assign gate.available_slots = available_q;
    assign gate.full            = full_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of the parking lot.
module tb_parking_gate_arbiter;
    localparam int unsigned N = 4;

    logic clock = 1'b0;
    logic gl_reset = 1'b1;
    always #5 clock = ~clock;

    parking_gate_arbiter_if bus ();

    parking_gate_arbiter #(.GATE_OPEN_CYCLES(N)) dut (
        .clock    (clock),
        .gl_reset (gl_reset),
        .gate     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Lot model: which slots hold a car, slot passcodes, and who goes next on a tie.
    bit m_occ[8];
    int codes[8] = '{1, 3, 6, 11, 19, 32, 53, 87};
    bit m_favor_entry;

    // Requester state driven onto the bus.
    bit       ereq = 0;
    bit       xreq = 0;
    bit [2:0] xs = 0;
    bit [7:0] xc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_cars();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_occ[i];
        return n;
    endfunction

    function automatic logic [7:0] m_occ_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic drive();
        bus.entry_req = ereq;
        bus.exit_req  = xreq;
        bus.exit_slot = xs;
        bus.exit_code = xc;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_occ"},   bus.occupancy, m_occ_vec());
        check({tag, "_avail"}, bus.available_slots, 8 - m_cars());
        check({tag, "_full"},  bus.full, m_cars() == 8);
    endtask

    task automatic do_reset();
        @(negedge clock);
        gl_reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 8; i++) m_occ[i] = 0;
        m_favor_entry = 0;
        check("rst_eack", bus.entry_ack, 0);
        check("rst_xack", bus.exit_ack, 0);
        check("rst_egate", bus.entry_gate_open, 0);
        check("rst_xgate", bus.exit_gate_open, 0);
        check("rst_eslot", bus.entry_slot, 0);
        check("rst_ecode", bus.entry_code, 0);
        check_status("rst");
        gl_reset = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn();
        bit se;
        bit g = 0;
        int es = 0;
        int ec = 0;
        drive();
        if (!ereq && !xreq) begin
            @(negedge clock);
            check("quiet_eack", bus.entry_ack, 0);
            check("quiet_xack", bus.exit_ack, 0);
            return;
        end
        se = ereq && (!xreq || m_favor_entry);
        m_favor_entry = !se;
        if (se) begin
            for (int i = 0; i < 8; i++) begin
                if (!g && !m_occ[i]) begin
                    g = 1; es = i; ec = codes[i]; m_occ[i] = 1;
                end
            end
        end else if (m_occ[xs] && xc == codes[xs]) begin
            g = 1; m_occ[xs] = 0;
        end
        @(negedge clock);
        check("eack", bus.entry_ack, se);
        check("xack", bus.exit_ack, !se);
        check("egrant", bus.entry_grant, se && g);
        check("xgrant", bus.exit_grant, !se && g);
        check("eslot", bus.entry_slot, es);
        check("ecode", bus.entry_code, ec);
        check("ack_egate", bus.entry_gate_open, 0);
        check("ack_xgate", bus.exit_gate_open, 0);
        check_status("ack");
        if (se) ereq = 0; else xreq = 0;
        drive();
        if (g) begin
            for (int i = 0; i < int'(N); i++) begin
                @(negedge clock);
                check("win_egate", bus.entry_gate_open, se);
                check("win_xgate", bus.exit_gate_open, !se);
                check("win_eack", bus.entry_ack | bus.exit_ack, 0);
            end
        end
        @(negedge clock);
        check("post_egate", bus.entry_gate_open, 0);
        check("post_xgate", bus.exit_gate_open, 0);
        check("post_ack", bus.entry_ack | bus.exit_ack, 0);
        check("post_eslot", bus.entry_slot, 0);
    endtask

    initial begin
        drive();
        do_reset();

        // Fill the lot, then one more entry finds it full.
        for (int i = 0; i < 9; i++) begin
            ereq = 1;
            run_txn();
        end

        // Valid exit of slot 3, then the next entry reuses slot 3.
        xreq = 1; xs = 3; xc = 11; run_txn();
        ereq = 1; run_txn();

        // Wrong code, then correct code for slot 5 twice (second time it is empty).
        xreq = 1; xs = 3; xc = 12; run_txn();
        xreq = 1; xs = 5; xc = 32; run_txn();
        xreq = 1; xs = 5; xc = 32; run_txn();

        // Simultaneous requests after reset with slot 0 occupied.
        do_reset();
        ereq = 1; run_txn();
        ereq = 1; xreq = 1; xs = 0; xc = 1; run_txn();
        run_txn();
        ereq = 1; xreq = 1; xs = 0; xc = 1; run_txn();
        run_txn();

        // Reset during the second gate cycle with the entry request held.
        do_reset();
        ereq = 1; drive();
        @(negedge clock);
        check("mr_eack", bus.entry_ack, 1);
        check("mr_eslot", bus.entry_slot, 0);
        @(negedge clock);
        check("mr_gate1", bus.entry_gate_open, 1);
        @(negedge clock);
        check("mr_gate2", bus.entry_gate_open, 1);
        gl_reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 8; i++) m_occ[i] = 0;
        m_favor_entry = 0;
        check("mr_gate_closed", bus.entry_gate_open, 0);
        check("mr_eack_rst", bus.entry_ack, 0);
        check_status("mr");
        @(negedge clock);
        check("mr_held_eack", bus.entry_ack, 0);
        gl_reset = 1'b0;
        run_txn();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if (!ereq && $urandom_range(0, 2) != 0) ereq = 1;
            if (!xreq && $urandom_range(0, 2) != 0) begin
                xreq = 1;
                xs = 3'($urandom_range(0, 7));
                xc = ($urandom_range(0, 3) != 0) ? 8'(codes[xs]) : 8'($urandom);
            end
            if ($urandom_range(0, 79) == 0) begin
                ereq = 0; xreq = 0; drive();
                do_reset();
            end else begin
                run_txn();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
